// File: rtl/seq_arith_unit.sv
// Clocked arithmetic unit: single-cycle ADD/SUB/SHR and an iterative shift-add MUL,
// with a valid/ready handshake on both the operand and the result side.
module seq_arith_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic [CNT_W-1:0]   ops_done,
  output logic [1:0]         dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready depends only on state; out_valid stays high with result stable until out_ready.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DONE     = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam int         BW     = $clog2(WIDTH + 1);

  state_t               state, state_n;
  logic [2*WIDTH-1:0]   mcand, acc, acc_n, result_q;
  logic [WIDTH-1:0]     mplier, shr_w;
  logic [BW-1:0]        bitcnt;
  logic [CNT_W-1:0]     ops_q;
  logic [WIDTH:0]       sum_w, diff_w;

  assign sum_w  = {1'b0, a} + {1'b0, b};
  assign diff_w = {1'b0, a} - {1'b0, b};
  assign shr_w  = a >> b;
  assign acc_n  = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = (op == OP_MUL) ? MUL_BUSY : DONE;
      end
      MUL_BUSY: begin
        busy = 1'b1;
        if (bitcnt == BW'(1)) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      bitcnt   <= '0;
      ops_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            case (op)
              OP_ADD: result_q <= {{(WIDTH-1){1'b0}}, sum_w};
              OP_SUB: result_q <= {{(WIDTH-1){1'b0}}, diff_w};
              OP_MUL: begin
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
                acc    <= '0;
                bitcnt <= BW'(WIDTH);
              end
              default: result_q <= {{WIDTH{1'b0}}, shr_w};
            endcase
          end
        end
        MUL_BUSY: begin
          acc    <= acc_n;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          bitcnt <= bitcnt - BW'(1);
          // The final iteration's sum goes straight into the result register.
          if (bitcnt == BW'(1)) result_q <= acc_n;
        end
        DONE: begin
          if (out_ready) ops_q <= ops_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign result    = result_q;
  assign ops_done  = ops_q;
  assign dbg_state = state;

endmodule
